// File: rtl/vco_adc_pkg.sv
// Shared definitions for the VCO ADC front end.
//   CNT_W_DEF / OSR_W_DEF : default edge-counter and window-control widths
//   OSR_MIN               : shortest legal window; smaller osr values clamp to it
//   vq_state_e            : quantizer run state
package vco_adc_pkg;
  localparam int CNT_W_DEF = 16;
  localparam int OSR_W_DEF = 10;
  localparam int OSR_MIN   = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2
  } vq_state_e;
endpackage

// File: rtl/vco_sync_edge.sv
// Two-flop synchronizer for the asynchronous VCO phase plus a rising-edge
// detector on the synchronized signal.
//   gclk     : system clock
//   grst_n   : asynchronous active-low reset
//   async_in : raw asynchronous input
//   edge_o   : one-cycle pulse per detected rising edge
module vco_sync_edge (
  input  logic gclk,
  input  logic grst_n,
  input  logic async_in,
  output logic edge_o
);
  // [0],[1] synchronize; [2] is the delayed copy used for edge detection
  logic [2:0] sync_pipe;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) sync_pipe <= '0;
    else         sync_pipe <= {sync_pipe[1:0], async_in};
  end

  assign edge_o = sync_pipe[1] & ~sync_pipe[2];
endmodule

// File: rtl/vco_edge_quantizer.sv
// Counts VCO phase rising edges over windows of osr_i clocks and emits one
// count per window on a valid/ready interface. Also drives the VCO's
// active-low enable.
//   wb_clk_i / wb_rst_ni : clock, async active-low reset
//   phase_in             : raw VCO phase (asynchronous)
//   enable_i             : run enable
//   osr_i                : window length (values below 2 clamp to 2)
//   clr_ovr_i            : clears overrun_o
//   vco_enb_o            : registered ~enable_i
//   sample_o / sample_valid_o / sample_ready_i : result handshake
//   overrun_o            : sticky, a RUN result was dropped
//   busy_o               : in SETTLE or RUN
module vco_edge_quantizer
  import vco_adc_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int OSR_W      = OSR_W_DEF,
  parameter int SETTLE_WIN = 1
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             phase_in,
  input  logic             enable_i,
  input  logic [OSR_W-1:0] osr_i,
  input  logic             clr_ovr_i,
  output logic             vco_enb_o,
  output logic [CNT_W-1:0] sample_o,
  output logic             sample_valid_o,
  input  logic             sample_ready_i,
  output logic             overrun_o,
  output logic             busy_o
);
  vq_state_e        state_q, state_d;
  logic [OSR_W-1:0] win_len_q, win_cnt_q, osr_len;
  logic [CNT_W-1:0] edge_cnt_q, edge_sum;
  logic [3:0]       settle_q;
  logic             edge_det, win_last, win_end, run_end, xfer, load, drop;

  vco_sync_edge u_sync (
    .gclk     (wb_clk_i),
    .grst_n   (wb_rst_ni),
    .async_in (phase_in),
    .edge_o   (edge_det)
  );

  assign osr_len  = (osr_i < OSR_W'(OSR_MIN)) ? OSR_W'(OSR_MIN) : osr_i;
  assign win_last = (win_cnt_q == (win_len_q - OSR_W'(1)));
  // Saturating count including this cycle's edge; on the last window cycle
  // this is the window result.
  assign edge_sum = (edge_det && (edge_cnt_q != {CNT_W{1'b1}})) ?
                    edge_cnt_q + CNT_W'(1) : edge_cnt_q;

  // A disable on the last cycle wins: the window is discarded.
  assign win_end = (state_q != IDLE) & enable_i & win_last;
  assign run_end = win_end & (state_q == RUN);
  assign xfer    = sample_valid_o & sample_ready_i;
  assign load    = run_end & (~sample_valid_o | xfer);
  assign drop    = run_end & sample_valid_o & ~sample_ready_i;
  assign busy_o  = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable_i) state_d = (SETTLE_WIN == 0) ? RUN : SETTLE;
      SETTLE:  if (!enable_i) state_d = IDLE;
               else if (win_last && settle_q == 4'd1) state_d = RUN;
      RUN:     if (!enable_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Window/edge counters. While idle (or on disable) they sit at zero and
  // win_len tracks osr_i so the first window uses the value present at enable.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      win_len_q  <= OSR_W'(OSR_MIN);
      win_cnt_q  <= '0;
      edge_cnt_q <= '0;
    end else if (state_q == IDLE || !enable_i) begin
      win_len_q  <= osr_len;
      win_cnt_q  <= '0;
      edge_cnt_q <= '0;
    end else if (win_last) begin
      win_len_q  <= osr_len;
      win_cnt_q  <= '0;
      edge_cnt_q <= '0;
    end else begin
      win_cnt_q  <= win_cnt_q + OSR_W'(1);
      edge_cnt_q <= edge_sum;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni)                        settle_q <= '0;
    else if (state_q == IDLE)              settle_q <= 4'(SETTLE_WIN);
    else if (state_q == SETTLE && win_end) settle_q <= settle_q - 4'd1;
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      vco_enb_o      <= 1'b1;
      sample_o       <= '0;
      sample_valid_o <= 1'b0;
      overrun_o      <= 1'b0;
    end else begin
      vco_enb_o <= ~enable_i;
      if (load) begin
        sample_o       <= edge_sum;
        sample_valid_o <= 1'b1;
      end else if (xfer) begin
        sample_valid_o <= 1'b0;
      end
      if (drop)           overrun_o <= 1'b1;
      else if (clr_ovr_i) overrun_o <= 1'b0;
    end
  end
endmodule

// File: tb/tb_vco_edge_quantizer.sv
module tb_vco_edge_quantizer;
  logic clk = 1'b0, rst_n = 1'b0, phase_in = 1'b0, enable = 1'b0, rdy = 1'b1, clr = 1'b0;
  logic [9:0]  osr = 10'd100;
  logic [15:0] s16;
  logic [3:0]  s4;
  logic enb, enb4, v16, v4, ovr, ovr4, busy, busy4;

  always #5 clk = ~clk;

  vco_edge_quantizer #(.CNT_W(16), .OSR_W(10), .SETTLE_WIN(1)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .phase_in(phase_in), .enable_i(enable),
    .osr_i(osr), .clr_ovr_i(clr), .vco_enb_o(enb), .sample_o(s16),
    .sample_valid_o(v16), .sample_ready_i(rdy), .overrun_o(ovr), .busy_o(busy));

  vco_edge_quantizer #(.CNT_W(4), .OSR_W(10), .SETTLE_WIN(1)) dut4 (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .phase_in(phase_in), .enable_i(enable),
    .osr_i(osr), .clr_ovr_i(clr), .vco_enb_o(enb4), .sample_o(s4),
    .sample_valid_o(v4), .sample_ready_i(rdy), .overrun_o(ovr4), .busy_o(busy4));

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d t=%0t", tag, act, exp, $time);
  endtask

  // Reference model: windows are spans of posedge indices; a window's result is
  // the number of synchronized rising edges landing in the span (edge seen at
  // posedge k when phase was high at k-2 and low at k-3), clamped to counter max.
  bit ph_eff [0:16383];
  int cyc = 0;
  int mode = 0;            // 0 idle, 1 settle, 2 run
  int wstart, wend, left;
  int m_s16 = 0, m_s4 = 0;
  bit m_valid = 0, m_ovr = 0, m_enb = 1;

  function automatic bit phe(int i);
    return (i < 0) ? 1'b0 : ph_eff[i];
  endfunction

  function automatic int nlen(int o);
    return (o < 2) ? 2 : o;
  endfunction

  task automatic model_reset();
    mode = 0; m_valid = 0; m_s16 = 0; m_s4 = 0; m_ovr = 0; m_enb = 1;
    for (int i = cyc - 2; i <= cyc; i++) if (i >= 0) ph_eff[i] = 1'b0;
  endtask

  task automatic model_tick();
    bit xfer, loaded, dropped;
    int cnt;
    if (!rst_n) begin
      ph_eff[cyc] = 1'b0;
      model_reset();
      return;
    end
    ph_eff[cyc] = phase_in;
    xfer = m_valid & rdy; loaded = 0; dropped = 0;
    if (mode == 0) begin
      if (enable) begin
        mode = 1; left = 1; wstart = cyc + 1; wend = cyc + nlen(osr);
      end
    end else if (!enable) begin
      mode = 0;
    end else if (cyc == wend) begin
      cnt = 0;
      for (int k = wstart; k <= wend; k++) cnt += (phe(k-2) & ~phe(k-3));
      if (mode == 1) begin
        left--;
        if (left == 0) mode = 2;
      end else if (!m_valid || xfer) begin
        m_s16 = (cnt > 65535) ? 65535 : cnt;
        m_s4  = (cnt > 15) ? 15 : cnt;
        loaded = 1;
      end else dropped = 1;
      wstart = cyc + 1; wend = cyc + nlen(osr);
    end
    if (loaded) m_valid = 1;
    else if (xfer) m_valid = 0;
    if (dropped) m_ovr = 1;
    else if (clr) m_ovr = 0;
    m_enb = !enable;
  endtask

  // Phase generator state
  int ph_hi = 5, ph_lo = 5, ph_t = 0, gen_edges = 0, acc = 0;
  bit ph_rand = 1;

  task automatic step();
    ph_t++;
    if (phase_in) begin
      if (ph_t >= ph_hi) begin
        phase_in = 1'b0; ph_t = 0;
        if (ph_rand) ph_lo = $urandom_range(2, 6);
      end
    end else if (ph_t >= ph_lo) begin
      phase_in = 1'b1; ph_t = 0; gen_edges++;
      if (ph_rand) ph_hi = $urandom_range(2, 6);
    end
    if (v16 && rdy) acc += int'(s16);
    @(posedge clk);
    cyc++;
    model_tick();
    @(negedge clk);
    chk("sample",  s16,  m_s16);
    chk("sample4", s4,   m_s4);
    chk("valid",   v16,  m_valid);
    chk("valid4",  v4,   m_valid);
    chk("overrun", ovr,  m_ovr);
    chk("vco_enb", enb,  m_enb);
    chk("busy",    busy, mode != 0);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_sample", s16, 0);
    chk("rst_valid",  v16, 0);
    chk("rst_ovr",    ovr, 0);
    chk("rst_enb",    enb, 1);
    chk("rst_busy",   busy, 0);
    @(negedge clk);
  endtask

  task automatic restart(input int o, input int hl);
    enable = 1'b0; steps(4);
    osr = 10'(o); ph_rand = 0; ph_hi = hl; ph_lo = hl;
    enable = 1'b1;
  endtask

  initial begin
    // Reset held with random phase
    steps(6);
    chk("rst_sample", s16, 0);
    chk("rst_valid",  v16, 0);
    chk("rst_ovr",    ovr, 0);
    chk("rst_enb",    enb, 1);
    rst_n = 1'b1;
    steps(5);
    chk("idle_enb",   enb, 1);
    chk("idle_valid", v16, 0);

    // Nominal: window 100, phase period 10
    restart(100, 5);
    steps(550);
    chk("nom_sample", s16, 10);
    chk("nom_ovr",    ovr, 0);

    // Clamp: osr=0 -> N=2, phase period 4; every edge counted once
    restart(0, 2);
    gen_edges = 0; acc = 0;
    steps(1000);
    enable = 1'b0;
    steps(4);
    chk("clamp_sum_tol", ((acc - gen_edges) <= 4 && (gen_edges - acc) <= 4), 1);

    // Backpressure / overrun / clear
    rdy = 1'b0;
    restart(20, 3);
    steps(65);
    chk("bp_valid", v16, 1);
    chk("bp_ovr",   ovr, 1);
    rdy = 1'b1;
    steps(3);
    chk("bp_drained", v16, 0);
    clr = 1'b1; step(); clr = 1'b0; step();
    chk("clr_ovr", ovr, 0);

    // Saturation of the 4-bit instance
    restart(200, 2);
    steps(420);
    chk("sat4",  s4,  15);
    chk("sat16", s16, 50);

    // Enable drop mid-window with a pending sample
    rdy = 1'b0;
    restart(100, 5);
    steps(200 + 37);
    enable = 1'b0;
    steps(20);
    chk("dis_valid",  v16,  1);
    chk("dis_sample", s16,  10);
    chk("dis_busy",   busy, 0);
    rdy = 1'b1; enable = 1'b1;
    steps(150);

    // Asynchronous reset mid-window
    steps(40);
    async_reset();
    steps(3);
    rst_n = 1'b1;
    steps(30);

    // Randomized operation
    ph_rand = 1;
    for (int i = 0; i < 3000; i++) begin
      rdy = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 15) == 0);
      if (i % 100 == 0) osr = 10'($urandom_range(0, 30));
      if ($urandom_range(0, 199) == 0) enable = ~enable;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
